// File: rtl/serial_adder_nb.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop add two N-bit operands
// plus carry-in over N cycles, with a start/busy/done handshake and held results.
module serial_adder_nb #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t        state_r, state_s;
    logic [N-1:0]  ra_r, ra_s;
    logic [N-1:0]  rb_r, rb_s;
    logic [N-1:0]  acc_r, acc_s;
    logic          carry_r, carry_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [N-1:0]  sum_r, sum_s;
    logic          cout_r, cout_s;
    logic          ovf_r, ovf_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          bit_s;
    logic          carry_out_s;

    // Next-state, datapath and result-register logic for the three-state sequencer.
    always_comb begin
        state_s     = state_r;
        ra_s        = ra_r;
        rb_s        = rb_r;
        acc_s       = acc_r;
        carry_s     = carry_r;
        cnt_s       = cnt_r;
        sum_s       = sum_r;
        cout_s      = cout_r;
        ovf_s       = ovf_r;
        bit_s       = ra_r[0] ^ rb_r[0] ^ carry_r;
        carry_out_s = majority(ra_r[0], rb_r[0], carry_r);

        case (state_r)
            IDLE: begin
                if (start) begin
                    ra_s    = A;
                    rb_s    = B;
                    carry_s = Cin;
                    cnt_s   = {CW{1'b0}};
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                ra_s    = {1'b0, ra_r[N-1:1]};
                rb_s    = {1'b0, rb_r[N-1:1]};
                acc_s   = {bit_s, acc_r[N-1:1]};
                carry_s = carry_out_s;
                cnt_s   = cnt_r + CW'(1);
                if (cnt_r == LAST_BIT) begin
                    // carry_r here is the carry into the MSB, needed for signed overflow
                    sum_s   = {bit_s, acc_r[N-1:1]};
                    cout_s  = carry_out_s;
                    ovf_s   = carry_r ^ carry_out_s;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    ra_s    = A;
                    rb_s    = B;
                    carry_s = Cin;
                    cnt_s   = {CW{1'b0}};
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s == RUN);
        done_s = (state_s == DONE);
    end

    // State and datapath registers; reset aborts any addition and clears the results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            ra_r    <= {N{1'b0}};
            rb_r    <= {N{1'b0}};
            acc_r   <= {N{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {N{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ra_r    <= ra_s;
            rb_r    <= rb_s;
            acc_r   <= acc_s;
            carry_r <= carry_s;
            cnt_r   <= cnt_s;
            sum_r   <= sum_s;
            cout_r  <= cout_s;
            ovf_r   <= ovf_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign S    = sum_r;
    assign Cout = cout_r;
    assign V    = ovf_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_adder_nb.sv
// Directed bench for serial_adder_nb: N=8 handshake/boundary cases and an N=4 exhaustive sweep.
module tb_serial_adder_nb;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] A, B, S;
    logic       Cin, Cout, V, busy, done;
    logic       start4;
    logic [3:0] A4, B4, S4;
    logic       Cin4, Cout4, V4, busy4, done4;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clock = ~clock;

    serial_adder_nb #(.N(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start), .A(A), .B(B), .Cin(Cin),
        .S(S), .Cout(Cout), .V(V), .busy(busy), .done(done)
    );

    serial_adder_nb #(.N(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .A(A4), .B(B4), .Cin(Cin4),
        .S(S4), .Cout(Cout4), .V(V4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done on the 8-bit instance; lat = edges after the load edge.
    task automatic wait_done8(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clock); #1;
            edges++;
        end
        check("done8_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c);
        A = a; B = b; Cin = c; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done8(lat);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
        start4 = 1'b0; A4 = 4'h0; B4 = 4'h0; Cin4 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_S",    {24'd0, S}, 32'h0);
        check("rst_Cout", {31'd0, Cout}, 32'd0);
        check("rst_V",    {31'd0, V}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // 0+0: busy during run, done 9 edges after (and including) the load edge
        A = 8'h00; B = 8'h00; Cin = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_run", {31'd0, busy}, 32'd1);
        wait_done8(lat);
        check("lat_edges", lat + 1, 32'd9);
        check("zero_S", {24'd0, S}, 32'h00);
        check("zero_Cout", {31'd0, Cout}, 32'd0);
        check("zero_V", {31'd0, V}, 32'd0);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        check("done_pulse", {31'd0, done}, 32'd0);

        add8(8'hFF, 8'h01, 1'b0);
        check("ff01", {23'd0, Cout, S, V}, {23'd0, 1'b1, 8'h00, 1'b0});
        @(posedge clock); #1;
        add8(8'h7F, 8'h01, 1'b0);
        check("7f01", {23'd0, Cout, S, V}, {23'd0, 1'b0, 8'h80, 1'b1});
        @(posedge clock); #1;
        add8(8'h0F, 8'hF0, 1'b1);
        check("0ff0c", {23'd0, Cout, S, V}, {23'd0, 1'b1, 8'h00, 1'b0});
        @(posedge clock); #1;
        add8(8'h80, 8'h80, 1'b0);
        check("8080", {23'd0, Cout, S, V}, {23'd0, 1'b1, 8'h00, 1'b1});
        @(posedge clock); #1;

        // Mid-run start and operand changes are ignored; S holds old result during RUN
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("hold_during_run", {23'd0, Cout, S, V}, {23'd0, 1'b1, 8'h00, 1'b1});
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done8(lat);
        check("ignore_start", {23'd0, Cout, S, V}, {23'd0, 1'b0, 8'h46, 1'b0});
        @(posedge clock); #1;
        check("idle_after", {30'd0, busy, done}, 32'd0);

        // Back-to-back: start held through DONE restarts with no idle gap
        A = 8'h50; B = 8'h50; Cin = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        A = 8'h01; B = 8'h02; Cin = 1'b1;
        wait_done8(lat);
        check("b2b_first", {23'd0, Cout, S, V}, {23'd0, 1'b0, 8'hA0, 1'b1});
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b_busy", {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
        check("b2b_hold", {24'd0, S}, 32'hA0);
        wait_done8(lat);
        check("b2b_lat", lat + 1, 32'd9);
        check("b2b_second", {23'd0, Cout, S, V}, {23'd0, 1'b0, 8'h04, 1'b0});
        @(posedge clock); #1;

        // Asynchronous reset at edge 4 of a run clears everything at once
        A = 8'hFF; B = 8'h01; Cin = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check("arst_S", {24'd0, S}, 32'h0);
        check("arst_flags", {29'd0, Cout, V, busy, done}, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        add8(8'h0F, 8'hF0, 1'b1);
        check("post_rst", {23'd0, Cout, S, V}, {23'd0, 1'b1, 8'h00, 1'b0});
        check("post_rst_lat", lat + 1, 32'd9);
        @(posedge clock); #1;

        // N=4 exhaustive sweep against an integer model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int sa, sb, ssum, edges;
                    logic ev;
                    A4 = a[3:0]; B4 = b[3:0]; Cin4 = c[0]; start4 = 1'b1;
                    @(posedge clock); #1;
                    start4 = 1'b0;
                    edges = 0;
                    while (!done4 && edges < 20) begin
                        @(posedge clock); #1;
                        edges++;
                    end
                    check("done4_timeout", {31'd0, done4}, 32'd1);
                    sa = (a > 7) ? a - 16 : a;
                    sb = (b > 7) ? b - 16 : b;
                    ssum = sa + sb + c;
                    ev = (ssum > 7) || (ssum < -8);
                    $display("%0d + %0d + %0d = %0d %0h", a, b, c, Cout4, S4);
                    check("n4_sum", {27'd0, Cout4, S4}, a + b + c);
                    check("n4_V", {31'd0, V4}, {31'd0, ev});
                    @(posedge clock); #1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
